// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared state type, widths and saturating counter helper for the frame arbiter
package axis_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      XFER = 2'd2
   } state_e;

   localparam int TDATA_W = 32;
   localparam int CNT_W   = 16;

   // Adds a small amount and clamps at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                input logic [3:0]       amt);
      logic [CNT_W:0] sum;
      sum = {1'b0, cnt} + {{(CNT_W-3){1'b0}}, amt};
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first requester at or after ptr, wrapping
module rr_arbiter #(
   parameter int N     = 2,
   parameter int PTR_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt
);

   logic found;
   int   idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_frame_arbiter.sv
// rtl/axis_frame_arbiter.sv - per-frame round-robin sharing of one 32-bit stream between NUM_SRC sources
module axis_frame_arbiter
   import axis_arb_pkg::*;
#(
   parameter int NUM_SRC        = 2,
   parameter int LEN_W          = 16,
   parameter bit DROP_UNALIGNED = 1'b1
) (
   input  logic                       s_axi_aclk,
   input  logic                       s_axi_aresetn,
   input  logic [LEN_W-1:0]           frame_len,
   input  logic [NUM_SRC-1:0]         s_axis_tvalid,
   output logic [NUM_SRC-1:0]         s_axis_tready,
   input  logic [NUM_SRC-1:0]         s_axis_sof,
   input  logic [TDATA_W*NUM_SRC-1:0] s_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_sof,
   output logic [TDATA_W-1:0]         m_axis_tdata,
   output logic [NUM_SRC-1:0]         grant,
   output logic [CNT_W-1:0]           drop_cnt,
   output logic [CNT_W-1:0]           sof_err_cnt
);

   localparam int PTR_W = $clog2(NUM_SRC);

   state_e             state, state_next;
   logic [PTR_W-1:0]   rr_ptr, grant_idx, arb_idx;
   logic [LEN_W-1:0]   len, beat_cnt;
   logic [NUM_SRC-1:0] req, arb_gnt, drain;
   logic               g_valid, g_sof, beat, last_beat;
   logic [3:0]         drain_n;

   assign req = s_axis_tvalid & s_axis_sof;

   rr_arbiter #(.N(NUM_SRC), .PTR_W(PTR_W)) u_rr (
      .req (req),
      .ptr (rr_ptr),
      .gnt (arb_gnt)
   );

   // grant is only non-zero in XFER, so the mux output is zero everywhere else
   always_comb begin
      g_valid      = 1'b0;
      g_sof        = 1'b0;
      m_axis_tdata = '0;
      arb_idx      = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant[i]) begin
            g_valid      = s_axis_tvalid[i];
            g_sof        = s_axis_sof[i];
            m_axis_tdata = s_axis_tdata[i*TDATA_W +: TDATA_W];
         end
         if (arb_gnt[i]) arb_idx = PTR_W'(i);
      end
   end

   assign m_axis_tvalid = (state == XFER) && g_valid;
   assign m_axis_sof    = m_axis_tvalid && (beat_cnt == '0);
   assign beat          = m_axis_tvalid && m_axis_tready;
   assign last_beat     = beat && (beat_cnt == len - LEN_W'(1));

   // Misaligned beats from non-owners are swallowed so they cannot block a later sof
   always_comb begin
      drain   = '0;
      drain_n = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         drain[i] = DROP_UNALIGNED && !grant[i] && s_axis_tvalid[i] && !s_axis_sof[i];
         drain_n  = drain_n + {3'b000, drain[i]};
         s_axis_tready[i] = s_axi_aresetn && (grant[i] ? m_axis_tready : drain[i]);
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (|req) state_next = ARB;
         ARB:     state_next = (|arb_gnt) ? XFER : IDLE;
         XFER:    if (last_beat) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) state <= IDLE;
      else                state <= state_next;
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         grant     <= '0;
         grant_idx <= '0;
         rr_ptr    <= '0;
         len       <= '0;
         beat_cnt  <= '0;
      end else if (state == ARB) begin
         grant     <= arb_gnt;
         grant_idx <= arb_idx;
         len       <= (frame_len == '0) ? LEN_W'(1) : frame_len;
         beat_cnt  <= '0;
      end else if (beat) begin
         if (last_beat) begin
            grant    <= '0;
            beat_cnt <= '0;
            rr_ptr   <= (grant_idx == PTR_W'(NUM_SRC-1)) ? '0 : grant_idx + 1'b1;
         end else begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         drop_cnt    <= '0;
         sof_err_cnt <= '0;
      end else begin
         if (drain_n != 4'd0) drop_cnt <= sat_inc(drop_cnt, drain_n);
         if (beat && g_sof && (beat_cnt != '0)) sof_err_cnt <= sat_inc(sof_err_cnt, 4'd1);
      end
   end

endmodule
